// File: rtl/alu_pkg.sv
// Shared type definitions for the ALU decoder and the execute stage.
package alu_pkg;

  // ALU operation codes produced by the decoder; other encodings are reserved.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alucontrol_t;

  // Shift types; encoding 2'b11 is reserved and behaves as SLL.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shtype_t;

  // Execute-stage control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } exec_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Shift datapath of the execute stage, purely combinational.
// Default build: shifts data by exactly one bit per evaluation.
// With ALU_BARREL_SHIFT_EN defined: full barrel shift by shamt.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       shtype,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [SHW-1:0]   shamt,
`endif
  output logic [WIDTH-1:0] result
);

`ifdef ALU_BARREL_SHIFT_EN
  // Full-distance shift; SRA sign-extends through the signed cast.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    result = data << shamt;
    case (shtype)
      SH_SRL:  result = data >> shamt;
      SH_SRA:  result = $unsigned($signed(data) >>> shamt);
      default: result = data << shamt;
    endcase
  end
`else
  // One-bit step; SRA replicates the MSB, reserved type behaves as SLL.
  always_comb begin
    result = {data[WIDTH-2:0], 1'b0};
    case (shtype)
      SH_SRL:  result = {1'b0, data[WIDTH-1:1]};
      SH_SRA:  result = {data[WIDTH-1], data[WIDTH-1:1]};
      default: result = {data[WIDTH-2:0], 1'b0};
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: logic/arithmetic ops complete in one cycle,
// shifts iterate one bit per cycle through alu_shift_step.
// Build option ALU_BARREL_SHIFT_EN: barrel shifter, shifts also complete in
// one cycle and the SHIFT state / counter are not built.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  input  logic [1:0]       shtype,
  input  logic             alu2src,
  input  logic             sltunsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  exec_state_t      state, state_next;
  logic             accept;
  logic             shift_start;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign accept = in_valid & in_ready;

`ifdef ALU_BARREL_SHIFT_EN
  // Barrel mode never needs the SHIFT state.
  assign shift_start = 1'b0;

  alu_shift_step #(.WIDTH(WIDTH)) u_shift (
    .data   (a),
    .shtype (shtype),
    .shamt  (b[SHW-1:0]),
    .result (shift_out)
  );
`else
  logic [1:0]     sh_q;
  logic [SHW-1:0] cnt_q;

  // A zero shift amount completes directly like a logic op.
  assign shift_start = alu2src & (b[SHW-1:0] != '0);

  // The result register doubles as the shift work register; it is hidden
  // while in SHIFT because out_valid is low there.
  alu_shift_step #(.WIDTH(WIDTH)) u_shift (
    .data   (result_q),
    .shtype (sh_q),
    .result (shift_out)
  );
`endif

  // Single-cycle logic/arithmetic result from the accepted operands.
  always_comb begin
    alu_out = '0;
    case (alucontrol)
      ALU_AND: alu_out = a & b;
      ALU_OR:  alu_out = a | b;
      ALU_ADD: alu_out = a + b;
      ALU_SUB: alu_out = a - b;
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}},
                          sltunsigned ? (a < b) : ($signed(a) < $signed(b))};
      default: alu_out = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = shift_start ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
        state_next = ST_DONE;
`else
        if (cnt_q == SHW'(1)) state_next = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (accept)         state_next = shift_start ? ST_SHIFT : ST_DONE;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; DONE with out_ready allows back-to-back issue.
  always_comb begin
    in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    out_valid = (state == ST_DONE);
  end

  // Result datapath: load on accept, step while shifting, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      sh_q     <= '0;
      cnt_q    <= '0;
`endif
    end else if (accept) begin
      if (alu2src) begin
`ifdef ALU_BARREL_SHIFT_EN
        result_q <= shift_out;
        zero_q   <= (shift_out == '0);
`else
        result_q <= a;
        zero_q   <= (a == '0);
        sh_q     <= shtype;
        cnt_q    <= b[SHW-1:0];
`endif
      end else begin
        result_q <= alu_out;
        zero_q   <= (alu_out == '0);
      end
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state == ST_SHIFT) begin
      result_q <= shift_out;
      zero_q   <= (shift_out == '0);
      cnt_q    <= cnt_q - SHW'(1);
    end
`endif
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes expected responses,
// a monitor pops and compares on every output transfer.
// Define ALU_BARREL_SHIFT_EN to check the barrel-shift build.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  alucontrol;
  logic [1:0]  shtype;
  logic        alu2src;
  logic        sltunsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alucontrol  (alucontrol),
    .shtype      (shtype),
    .alu2src     (alu2src),
    .sltunsigned (sltunsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic int shift_lat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  // Present one operation starting at a negedge; push its expectation when accepted.
  task automatic issue(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [2:0] c, input logic [1:0] s, input logic src,
                       input logic u, input logic [31:0] er, input logic ez,
                       input int el, output int waits);
    exp_t e;
    waits       = 0;
    a           = av;
    b           = bv;
    alucontrol  = c;
    shtype      = s;
    alu2src     = src;
    sltunsigned = u;
    in_valid    = 1'b1;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      check({name, " accept timeout"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    e.res = er;
    e.z   = ez;
    e.lat = el;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: records first out_valid cycle, compares on each transfer.
  logic valid_seen = 1'b0;
  int   first_cyc  = 0;
  always @(negedge clk) begin
    #2;
    if (out_valid && !valid_seen) begin
      valid_seen = 1'b1;
      first_cyc  = cyc;
    end
    if (out_valid && out_ready) begin
      valid_seen = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, " result"},  result,                    e.res);
        check({n, " zero"},    32'(zero),                 32'(e.z));
        check({n, " latency"}, 32'(first_cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  initial begin : stim
    int w;
    logic saw_valid;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    alucontrol  = '0;
    shtype      = '0;
    alu2src     = 1'b0;
    sltunsigned = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result",    result,         32'd0);
    check("reset zero",      32'(zero),      32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);

    // Single-cycle operations, issued back to back.
    issue("add_ovf",  32'h7FFF_FFFF, 32'd1,   3'b010, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1, w);
    issue("sub_eq",   32'd5,         32'd5,   3'b110, 2'b00, 1'b0, 1'b0, 32'd0,         1'b1, 1, w);
    issue("slt_s",    32'hFFFF_FFFF, 32'd1,   3'b111, 2'b00, 1'b0, 1'b0, 32'd1,         1'b0, 1, w);
    issue("slt_u",    32'hFFFF_FFFF, 32'd1,   3'b111, 2'b00, 1'b0, 1'b1, 32'd0,         1'b1, 1, w);
    issue("or",       32'h0000_F000, 32'hF,   3'b001, 2'b00, 1'b0, 1'b0, 32'h0000_F00F, 1'b0, 1, w);
    issue("reserved", 32'd5,         32'd3,   3'b011, 2'b00, 1'b0, 1'b0, 32'd0,         1'b1, 1, w);

    // Shifts; alucontrol set to ADD to confirm alu2src overrides it.
    issue("sra31",    32'h8000_0000, 32'd31,  3'b010, 2'b10, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, shift_lat(31), w);
    issue("sll0",     32'd1,         32'd0,   3'b010, 2'b00, 1'b1, 1'b0, 32'd1,         1'b0, 1, w);
    issue("srl4",     32'h0000_00F0, 32'd4,   3'b010, 2'b01, 1'b1, 1'b0, 32'h0000_000F, 1'b0, shift_lat(4), w);
    issue("sh_rsvd",  32'd3,         32'd2,   3'b010, 2'b11, 1'b1, 1'b0, 32'h0000_000C, 1'b0, shift_lat(2), w);
    issue("sll_hib",  32'd1,         32'h23,  3'b010, 2'b00, 1'b1, 1'b0, 32'd8,         1'b0, shift_lat(3), w);
    issue("sra_pos",  32'h0000_0040, 32'd2,   3'b010, 2'b10, 1'b1, 1'b0, 32'h0000_0010, 1'b0, shift_lat(2), w);
    issue("srl_zero", 32'd1,         32'd1,   3'b010, 2'b01, 1'b1, 1'b0, 32'd0,         1'b1, shift_lat(1), w);

    // Output stall: result held stable and no new issue accepted.
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    out_ready = 1'b0;
    issue("and_stall", 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 2'b00, 1'b0, 1'b0, 32'h0000_00F0, 1'b0, 1, w);
    saw_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!(out_valid && !in_ready && result == 32'h0000_00F0 && !zero)) saw_valid = 1'b0;
      @(negedge clk);
    end
    check("stall hold", 32'(saw_valid), 32'd1);
    out_ready = 1'b1;
    issue("add_after_stall", 32'd2, 32'd3, 3'b010, 2'b00, 1'b0, 1'b0, 32'd5, 1'b0, 1, w);
    check("stall release accept waits", 32'(w), 32'd0);

    // Reset in the middle of a long shift discards the operation.
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    a = 32'd1; b = 32'd20; alucontrol = 3'b000; shtype = 2'b00; alu2src = 1'b1;
    in_valid = 1'b1;
    #1;
    check("midshift accept ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    #1;
    check("midshift no out_valid", 32'(saw_valid), 32'd0);
    check("midshift result",       result,         32'd0);
    check("midshift in_ready",     32'(in_ready),  32'd1);

    // Drain anything still outstanding.
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
